// File: rtl/keypad_scan4x4_if.sv
// keypad_scan4x4_if: keypad matrix lines and decoded-key outputs; key_seg exists only with KEYPAD_SEG_EN
interface keypad_scan4x4_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic key_valid;
  logic key_held;
`ifdef KEYPAD_SEG_EN
  logic [6:0] key_seg;
  modport master(output row_n, key_code, key_valid, key_held, key_seg, input col_n);
  modport slave(input row_n, key_code, key_valid, key_held, key_seg, output col_n);
`else
  modport master(output row_n, key_code, key_valid, key_held, input col_n);
  modport slave(input row_n, key_code, key_valid, key_held, output col_n);
`endif
endinterface

// File: rtl/keypad_scan4x4.sv
// keypad_scan4x4: 4x4 matrix keypad scanner with ghost rejection and frame-level debounce.
// Optional macro KEYPAD_SEG_EN adds the key_seg active-low hex glyph output.
module keypad_scan4x4 #(
  parameter int SCAN_DIV_BITS = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic clock,
  input logic reset_n,
  keypad_scan4x4_if.master kp
);
  localparam logic [4:0] NONE = 5'h10;
`ifdef KEYPAD_SEG_EN
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
`endif
  logic [SCAN_DIV_BITS-1:0] presc;
  logic [1:0] row_idx;
  logic [3:0] c1, c2;
  logic [15:0] map, full;
  logic [4:0] res, cand, stable, stable_nx;
  logic [3:0] cnt, cnt_nx;
  logic samp, frame_end;
  assign samp = &presc;
  assign frame_end = samp && row_idx == 2'd3;
  assign full = map | ({12'b0, ~c2} << {row_idx, 2'b00});
  // exactly one bit set yields its index; none or several (ghosting) yields NONE
  always_comb begin
    res = NONE;
    for (int i = 0; i < 16; i++)
      if (full == (16'b1 << i)) res = 5'(i);
  end
  always_comb begin
    cnt_nx = (res == cand) ? ((cnt == 4'hf) ? cnt : cnt + 4'd1) : 4'd1;
    stable_nx = (cnt_nx == 4'(DEBOUNCE_SCANS) && res != stable) ? res : stable;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      c1 <= 4'hf;
      c2 <= 4'hf;
      presc <= '0;
      row_idx <= 2'd0;
      kp.row_n <= 4'b1110;
      map <= '0;
      cand <= NONE;
      stable <= NONE;
      cnt <= 4'd0;
      kp.key_code <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.key_held <= 1'b0;
`ifdef KEYPAD_SEG_EN
      kp.key_seg <= 7'b0000001;
`endif
    end else begin
      c1 <= kp.col_n;
      c2 <= c1;
      presc <= presc + SCAN_DIV_BITS'(1);
      kp.key_valid <= 1'b0;
      if (samp) begin
        row_idx <= row_idx + 2'd1;
        kp.row_n <= ~(4'b1 << (row_idx + 2'd1));
        map <= frame_end ? '0 : full;
      end
      if (frame_end) begin
        cand <= res;
        cnt <= cnt_nx;
        stable <= stable_nx;
        if (stable_nx != stable) begin
          kp.key_held <= !stable_nx[4];
          kp.key_valid <= !stable_nx[4];
          if (!stable_nx[4]) kp.key_code <= stable_nx[3:0];
`ifdef KEYPAD_SEG_EN
          kp.key_seg <= stable_nx[4] ? 7'b1111111 : GLYPH[stable_nx[3:0]];
`endif
        end
      end
    end
endmodule
